uart_async_receiver: RTL and testbench

Oversampling RS-232 receive path for the UART protocol block, companion to the 8N2 transmitter. Accepts asynchronous serial line RxD, synchronizes and glitch-filters it on an externally generated oversampling tick, and recovers 8-bit, no-parity, LSB-first frames with one stop bit checked. Additional stop bits are treated as idle. Delivers each byte as a one-cycle strobe to the host-side logic and flags framing errors. Optionally detects inter-packet line gaps.

---
 rtl/uart_async_receiver.sv | 199 +++++++++++++++++++
 tb/tb_uart_async_receiver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_async_receiver.sv
// uart_async_receiver: oversampled 8N1 receive path with synchronizer, glitch filter and stop-bit check.
// Inter-packet gap detection (RxD_idle / RxD_endofpacket) is built only when UART_RX_IDLE_DETECT_EN is defined.
module uart_async_receiver #(
    parameter int unsigned OVERSAMPLING = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       OversamplingTick,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data,
    output logic       RxD_frame_error,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);

    localparam int unsigned   CW        = $clog2(OVERSAMPLING);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(OVERSAMPLING / 2 - 3);

    localparam logic [3:0] ST_IDLE  = 4'b0000;
    localparam logic [3:0] ST_START = 4'b0001;
    localparam logic [3:0] ST_STOP  = 4'b0010;
    localparam logic [3:0] ST_BIT0  = 4'b1000;
    localparam logic [3:0] ST_BIT1  = 4'b1001;
    localparam logic [3:0] ST_BIT2  = 4'b1010;
    localparam logic [3:0] ST_BIT3  = 4'b1011;
    localparam logic [3:0] ST_BIT4  = 4'b1100;
    localparam logic [3:0] ST_BIT5  = 4'b1101;
    localparam logic [3:0] ST_BIT6  = 4'b1110;
    localparam logic [3:0] ST_BIT7  = 4'b1111;

    if (OVERSAMPLING != 8 && OVERSAMPLING != 16) begin : g_bad_oversampling
        $error("uart_async_receiver: OVERSAMPLING must be 8 or 16");
    end

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    filt_cnt_q, filt_cnt_d;
    logic          filt_bit_q, filt_bit_d;
    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          ferr_q, ferr_d;
    logic          sample_now;

    // Line front end: two-flop synchronizer, then tick-driven saturating majority filter.
    always_comb begin
        sync_d     = {sync_q[0], RxD};
        filt_cnt_d = filt_cnt_q;
        filt_bit_d = filt_bit_q;
        if (OversamplingTick) begin
            if (sync_q[1]) begin
                if (filt_cnt_q != 2'd3) begin
                    filt_cnt_d = filt_cnt_q + 2'd1;
                end else begin
                    filt_cnt_d = filt_cnt_q;
                end
            end else begin
                if (filt_cnt_q != 2'd0) begin
                    filt_cnt_d = filt_cnt_q - 2'd1;
                end else begin
                    filt_cnt_d = filt_cnt_q;
                end
            end
            if (filt_cnt_d == 2'd0) begin
                filt_bit_d = 1'b0;
            end else if (filt_cnt_d == 2'd3) begin
                filt_bit_d = 1'b1;
            end else begin
                filt_bit_d = filt_bit_q;
            end
        end else begin
            filt_cnt_d = filt_cnt_q;
            filt_bit_d = filt_bit_q;
        end
    end

    // Sample point sits early in the bit to cancel the filter's three-tick lag.
    assign sample_now = OversamplingTick && (cnt_q == SAMPLE_AT);

    // Bit-phase counter and frame state machine.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            cnt_d = {CW{1'b0}};
        end else if (OversamplingTick) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (OversamplingTick && !filt_bit_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = state_q;
                end
            end
            ST_START: begin
                if (sample_now) begin
                    state_d = filt_bit_q ? ST_IDLE : ST_BIT0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_BIT0, ST_BIT1, ST_BIT2, ST_BIT3, ST_BIT4, ST_BIT5, ST_BIT6, ST_BIT7: begin
                if (sample_now) begin
                    data_d = {filt_bit_q, data_q[7:1]};
                    if (state_q == ST_BIT7) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = state_q + 4'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_STOP: begin
                if (sample_now) begin
                    state_d = ST_IDLE;
                    ready_d = filt_bit_q;
                    ferr_d  = ~filt_bit_q;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Receive path registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            filt_cnt_q <= 2'd3;
            filt_bit_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            data_q     <= 8'h00;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            filt_cnt_q <= filt_cnt_d;
            filt_bit_q <= filt_bit_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
        end
    end

    assign RxD_data_ready  = ready_q;
    assign RxD_data        = data_q;
    assign RxD_frame_error = ferr_q;

`ifdef UART_RX_IDLE_DETECT_EN
    localparam int unsigned GW = CW + 2;

    logic [GW-1:0] gap_q, gap_d;
    logic          eop_q, eop_d;

    // Gap counter restarts with each good byte and saturates once its MSB (two bit periods) sets.
    always_comb begin
        if (ready_d) begin
            gap_d = {GW{1'b0}};
        end else if (OversamplingTick && (state_q == ST_IDLE) && !gap_q[GW-1]) begin
            gap_d = gap_q + {{(GW-1){1'b0}}, 1'b1};
        end else begin
            gap_d = gap_q;
        end
        eop_d = gap_d[GW-1] & ~gap_q[GW-1];
    end

    // Gap registers; all-ones at reset so the line reads idle without an end-of-packet strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q <= {GW{1'b1}};
            eop_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
            eop_q <= eop_d;
        end
    end

    assign RxD_idle        = gap_q[GW-1];
    assign RxD_endofpacket = eop_q;
`else
    assign RxD_idle        = 1'b0;
    assign RxD_endofpacket = 1'b0;
`endif

endmodule

// File: tb/tb_uart_async_receiver.sv
// Self-checking bench for uart_async_receiver: directed frames plus random byte bursts against a byte-queue model.
`timescale 1ns/1ps
module tb_uart_async_receiver;

    localparam int OS = 8;
`ifdef UART_RX_IDLE_DETECT_EN
    localparam logic EXP_IDLE_RST = 1'b1;
`else
    localparam logic EXP_IDLE_RST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       rxd;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       RxD_frame_error;
    logic       RxD_idle;
    logic       RxD_endofpacket;

    int checks   = 0;
    int failures = 0;
    int tick_div = 1;
    bit tick_en  = 1'b1;

    int         ready_cnt = 0, ferr_cnt = 0, eop_cnt = 0, both_cnt = 0, idle_hi_cnt = 0;
    int         cyc = 0, last_ready_cyc = 0, last_eop_cyc = 0;
    logic       idle_at_ready = 1'b1;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_async_receiver #(.OVERSAMPLING(OS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .OversamplingTick (tick),
        .RxD              (rxd),
        .RxD_data_ready   (RxD_data_ready),
        .RxD_data         (RxD_data),
        .RxD_frame_error  (RxD_frame_error),
        .RxD_idle         (RxD_idle),
        .RxD_endofpacket  (RxD_endofpacket)
    );

    always #5 clk = ~clk;

    // Oversampling tick: one clk high every tick_div clks while enabled.
    initial begin
        int ph;
        ph   = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                tick = (ph == 0);
                ph   = (ph + 1 >= tick_div) ? 0 : ph + 1;
            end else begin
                tick = 1'b0;
            end
        end
    end

    // Output monitor: records strobes and delivered bytes on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (RxD_data_ready) begin
            ready_cnt++;
            got_q.push_back(RxD_data);
            last_ready_cyc = cyc;
            idle_at_ready  = RxD_idle;
        end
        if (RxD_frame_error) ferr_cnt++;
        if (RxD_data_ready && RxD_frame_error) both_cnt++;
        if (RxD_endofpacket) begin
            eop_cnt++;
            last_eop_cyc = cyc;
        end
        if (RxD_idle) idle_hi_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_clks(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (OS * tick_div) @(negedge clk);
    endtask

    // good=0 drives the stop bit low only for its first half so the line is idle again before re-arming.
    task automatic send_frame(input logic [7:0] b, input bit good, input int pause_at);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (i == pause_at) begin
                tick_en = 1'b0;
                repeat (20) @(negedge clk);
                tick_en = 1'b1;
            end
        end
        if (good) begin
            exp_q.push_back(b);
            send_bit(1'b1);
        end else begin
            rxd = 1'b0;
            repeat (4) @(negedge clk);
            rxd = 1'b1;
            repeat (OS * tick_div - 4) @(negedge clk);
        end
    endtask

    task automatic check_burst(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int r0, f0, e0, gap;
        logic [7:0] b, last_b;
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("rst_data", 32'(RxD_data), 32'h00);
        chk("rst_ready", 32'(RxD_data_ready), 32'h0);
        chk("rst_ferr", 32'(RxD_frame_error), 32'h0);
        chk("rst_idle", 32'(RxD_idle), 32'(EXP_IDLE_RST));
        chk("rst_eop", 32'(RxD_endofpacket), 32'h0);

        // Single good frame.
        r0 = ready_cnt; f0 = ferr_cnt;
        idle_clks(20);
        send_frame(8'h55, 1'b1, -1);
        idle_clks(30);
        settle();
        chk("good_ready_pulses", ready_cnt - r0, 1);
        chk("good_ferr_pulses", ferr_cnt - f0, 0);
        chk("good_data", 32'(RxD_data), 32'h55);
        check_burst("good");

        // Framing error, then a normal frame.
        r0 = ready_cnt; f0 = ferr_cnt;
        idle_clks(20);
        send_frame(8'hA3, 1'b0, -1);
        idle_clks(3 * OS);
        settle();
        chk("ferr_pulses", ferr_cnt - f0, 1);
        chk("ferr_no_ready", ready_cnt - r0, 0);
        chk("ferr_data_visible", 32'(RxD_data), 32'hA3);
        idle_clks(2 * OS);
        send_frame(8'h3C, 1'b1, -1);
        idle_clks(30);
        settle();
        chk("after_ferr_data", 32'(RxD_data), 32'h3C);
        check_burst("after_ferr");

        // Glitches of 2 and 1 ticks must not start a frame.
        r0 = ready_cnt; f0 = ferr_cnt;
        idle_clks(20);
        for (int k = 0; k < 8; k++) begin
            rxd = 1'b0;
            repeat ((k % 2) + 1) @(negedge clk);
            rxd = 1'b1;
            repeat (7) @(negedge clk);
        end
        idle_clks(12 * OS);
        settle();
        chk("glitch_ready", ready_cnt - r0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_data", 32'(RxD_data), 32'h3C);
        idle_clks(4);
        send_frame(8'h96, 1'b1, -1);
        idle_clks(30);
        settle();
        check_burst("post_glitch");

        // Back-to-back frames with one stop bit.
        idle_clks(20);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle_clks(30);
        settle();
        check_burst("b2b");

        // Tick stalled mid-frame freezes the receiver.
        idle_clks(20);
        send_frame(8'hC5, 1'b1, 3);
        idle_clks(30);
        settle();
        check_burst("tick_pause");

        // Gap detection after a good byte.
        idle_clks(40);
        settle();
        e0 = eop_cnt;
        idle_clks(2);
        send_frame(8'h5A, 1'b1, -1);
        idle_clks(40);
        settle();
`ifdef UART_RX_IDLE_DETECT_EN
        chk("idle_low_at_byte", 32'(idle_at_ready), 32'h0);
        chk("eop_pulses", eop_cnt - e0, 1);
        chk("eop_delay", last_eop_cyc - last_ready_cyc, 2 * OS);
        chk("idle_after_gap", 32'(RxD_idle), 32'h1);
`else
        chk("idle_tied_low", 32'(RxD_idle), 32'h0);
        chk("eop_tied_low", eop_cnt - e0, 0);
`endif
        check_burst("gap");

        // Random bytes, random gaps (0 = back-to-back) and tick rates.
        last_b = 8'h00;
        for (int f = 0; f < 24; f++) begin
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
            if (gap > 0) begin
                tick_div = int'($urandom_range(1, 2));
                idle_clks(gap);
            end
            b = 8'($urandom);
            last_b = b;
            send_frame(b, 1'b1, -1);
        end
        idle_clks(60);
        settle();
        chk("rand_last_data", 32'(RxD_data), 32'(last_b));
        check_burst("rand");
        tick_div = 1;

        // Reset in the middle of BIT3 of 0x81 discards the frame.
        idle_clks(20);
        r0 = ready_cnt; f0 = ferr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        rxd   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("midrst_data", 32'(RxD_data), 32'h00);
        chk("midrst_ready", 32'(RxD_data_ready), 32'h0);
        chk("midrst_ferr", 32'(RxD_frame_error), 32'h0);
        chk("midrst_idle", 32'(RxD_idle), 32'(EXP_IDLE_RST));
        chk("midrst_eop", 32'(RxD_endofpacket), 32'h0);
        idle_clks(12 * OS);
        settle();
        chk("midrst_no_ready", ready_cnt - r0, 0);
        chk("midrst_no_ferr", ferr_cnt - f0, 0);
        idle_clks(2);
        send_frame(8'h7E, 1'b1, -1);
        idle_clks(30);
        settle();
        chk("midrst_next_pulses", ready_cnt - r0, 1);
        chk("midrst_next_data", 32'(RxD_data), 32'h7E);
        check_burst("midrst_next");

        chk("strobes_exclusive", both_cnt, 0);
`ifndef UART_RX_IDLE_DETECT_EN
        chk("idle_never_high", idle_hi_cnt, 0);
        chk("eop_never_high", eop_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
